// File: rtl/mfp_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : mfp_input_debouncer
// Purpose  : Conditions raw board inputs (16 switches, 5 pushbuttons) for
//            the GPIO slave. Each bit passes through a 2-flop synchroniser.
//            It then passes through a stability counter. The output level
//            changes only after the synchronised input has differed from
//            it for STABLE_CYCLES consecutive clocks. A one-cycle change
//            strobe marks every accepted toggle.
// Option   : `define MFP_DEBOUNCE_STICKY_IRQ_EN adds sticky change flags
//            (write-1-to-clear) and a masked, registered interrupt. When it
//            is not defined, chg_sticky and irq are tied to 0 and
//            chg_clr / irq_mask are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mfp_input_debouncer #(
  parameter int WIDTH         = 21,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] change,
  input  logic [WIDTH-1:0] chg_clr,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] chg_sticky,
  output logic             irq
);

  localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_clean;
  logic [WIDTH-1:0] r_change;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_fire;

  // Two-stage synchroniser; no logic between stages so the first flop can settle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_clean;

  // Per-bit stability counters. A bit fires when it has differed for the full
  // window; any cycle of agreement discards the partial count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;

    assign w_fire[i] = w_diff[i] && (r_cnt == c_CNT_LAST);

    // Count consecutive differing cycles; clear on agreement or on acceptance
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        r_cnt <= '0;
      end else if (!w_diff[i] || w_fire[i]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Accept new levels and emit a single-cycle strobe on every accepted toggle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_clean  <= '0;
      r_change <= '0;
    end else begin
      r_clean  <= r_clean ^ w_fire;
      r_change <= w_fire;
    end
  end

  assign clean_out = r_clean;
  assign change    = r_change;

`ifdef MFP_DEBOUNCE_STICKY_IRQ_EN
  logic [WIDTH-1:0] r_sticky;
  logic [WIDTH-1:0] w_sticky_nxt;
  logic             r_irq;

  // A new toggle sets its flag even when software clears it on the same edge
  assign w_sticky_nxt = (r_sticky & ~chg_clr) | w_fire;

  // Sticky flags plus interrupt computed from the flags' next value
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sticky <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sticky <= w_sticky_nxt;
      r_irq    <= |(w_sticky_nxt & irq_mask);
    end
  end

  assign chg_sticky = r_sticky;
  assign irq        = r_irq;
`else
  logic w_unused_ok;

  assign chg_sticky  = '0;
  assign irq         = 1'b0;
  assign w_unused_ok = &{1'b0, chg_clr, irq_mask};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfp_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_input_debouncer
// Purpose  : Self-checking bench for mfp_input_debouncer (STABLE_CYCLES=4).
//            The bench uses a cycle-by-cycle vector table for the level and
//            strobe behaviour. It adds hand sequences for reset, reset
//            during a count, and the sticky/irq path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_input_debouncer;

  localparam int          WIDTH         = 21;
  localparam int          STABLE_CYCLES = 4;
  localparam logic [20:0] ALL           = 21'h1FFFFF;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [20:0] raw_in;
  logic [20:0] chg_clr;
  logic [20:0] irq_mask;
  logic [20:0] clean_out;
  logic [20:0] change;
  logic [20:0] chg_sticky;
  logic        irq;

  always #5 HCLK = ~HCLK;

  mfp_input_debouncer #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .raw_in    (raw_in),
    .clean_out (clean_out),
    .change    (change),
    .chg_clr   (chg_clr),
    .irq_mask  (irq_mask),
    .chg_sticky(chg_sticky),
    .irq       (irq)
  );

  typedef struct {
    logic [20:0] raw;
    logic [20:0] clean;
    logic [20:0] chg;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [20:0] m_sticky;
  logic        m_irq;

  function automatic void push(input logic [20:0] r, input logic [20:0] c, input logic [20:0] ch);
    vec_t v;
    v.raw   = r;
    v.clean = c;
    v.chg   = ch;
    vecs.push_back(v);
  endfunction

  // Hold raw for 7 edges: level flips on the 6th (E+5), strobe only there
  function automatic void push_step(input logic [20:0] r, input logic [20:0] old_c, input logic [20:0] new_c);
    for (int k = 0; k < 7; k++) begin
      push(r, (k >= 5) ? new_c : old_c, (k == 5) ? (old_c ^ new_c) : 21'h0);
    end
  endfunction

  task automatic cmp(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock edge, then compare all outputs against expectations/model
  task automatic tick_check(input string name, input logic [20:0] ec, input logic [20:0] ech);
    logic [20:0] clr;
    clr = chg_clr;
    @(posedge HCLK);
    #1;
    if (!HRESETn) begin
      m_sticky = '0;
    end else begin
`ifdef MFP_DEBOUNCE_STICKY_IRQ_EN
      m_sticky = (m_sticky & ~clr) | ech;
`else
      m_sticky = '0;
`endif
    end
    m_irq = |(m_sticky & irq_mask);
    cmp({name, ".clean"},  clean_out,      ec);
    cmp({name, ".change"}, change,         ech);
    cmp({name, ".sticky"}, chg_sticky,     m_sticky);
    cmp({name, ".irq"},    {20'h0, irq},   {20'h0, m_irq});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    HRESETn  = 1'b0;
    raw_in   = ALL;
    chg_clr  = '0;
    irq_mask = 21'h8;
    m_sticky = '0;
    m_irq    = 1'b0;

    // Reset held with all inputs high: everything stays 0
    repeat (10) tick_check("reset", 21'h0, 21'h0);
    HRESETn = 1'b1;
    for (int k = 0; k < 7; k++)
      tick_check($sformatf("release_k%0d", k), (k >= 5) ? ALL : 21'h0, (k == 5) ? ALL : 21'h0);

    // Vector table
    push_step(21'h0, ALL, 21'h0);                  // all fall together
    push_step(21'h1, 21'h0, 21'h1);                // single step on bit 0
    for (int k = 0; k < 3; k++) push(21'h21, 21'h1, 21'h0);  // 3-clock glitch on bit 5
    for (int k = 0; k < 6; k++) push(21'h01, 21'h1, 21'h0);
    for (int k = 0; k < 5; k++) push(21'h21, 21'h1, 21'h0);  // 5-clock pulse on bit 5
    push(21'h01, 21'h21, 21'h20);
    for (int k = 0; k < 4; k++) push(21'h01, 21'h21, 21'h0);
    push(21'h01, 21'h01, 21'h20);
    push(21'h01, 21'h01, 21'h0);
    push_step(21'h0abcd, 21'h1, 21'h0abcd);
    push_step(21'h01234, 21'h0abcd, 21'h01234);    // strobe 16'hb9f9
    push_step(21'h0, 21'h01234, 21'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      raw_in = vecs[i].raw;
      tick_check($sformatf("vec%0d", i), vecs[i].clean, vecs[i].chg);
    end

    // Reset in the middle of a bit-2 count aborts it
    raw_in = 21'h4;
    repeat (2) tick_check("midcnt_pre", 21'h0, 21'h0);
    HRESETn = 1'b0;
    tick_check("midcnt_rst", 21'h0, 21'h0);
    HRESETn = 1'b1;
    for (int k = 0; k < 7; k++)
      tick_check($sformatf("midcnt_k%0d", k), (k >= 5) ? 21'h4 : 21'h0, (k == 5) ? 21'h4 : 21'h0);

    // Sticky flags and masked interrupt on bit 3
    chg_clr = ALL;
    tick_check("clr_all", 21'h4, 21'h0);
    chg_clr = '0;
    raw_in  = 21'hC;
    for (int k = 0; k < 7; k++)
      tick_check($sformatf("b3set_k%0d", k), (k >= 5) ? 21'hC : 21'h4, (k == 5) ? 21'h8 : 21'h0);
    chg_clr = 21'h8;
    tick_check("b3clr", 21'hC, 21'h0);
    chg_clr = '0;
    tick_check("b3idle", 21'hC, 21'h0);
    raw_in = 21'h4;
    for (int k = 0; k < 7; k++) begin
      chg_clr = (k == 5) ? 21'h8 : 21'h0;
      tick_check($sformatf("setwins_k%0d", k), (k >= 5) ? 21'h4 : 21'hC, (k == 5) ? 21'h8 : 21'h0);
    end
    chg_clr = '0;
    tick_check("final", 21'h4, 21'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
